// File: rtl/pa_tx_sequencer.sv
// pa_tx_sequencer: owns the antenna handover for one transmit burst.
// LNA off -> guard -> PA bias on -> settle -> stream samples -> PA off -> guard -> LNA back on.
// All outputs come from registers. The one exception is TxDataReady, which is masked by
// Abort so that a sample offered in the abort cycle is never taken.
module pa_tx_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 8,
  parameter int DEAD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  TxRequest,
  input  logic [LEN_WIDTH-1:0]  TxLength,
  output logic                  TxAccept,
  input  logic [DATA_WIDTH-1:0] TxData,
  input  logic                  TxDataValid,
  output logic                  TxDataReady,
  input  logic                  Abort,
  output logic [DATA_WIDTH-1:0] Transmit,
  output logic                  TransmitValid,
  output logic                  EnableTransmit,
  output logic                  EnableReceive,
  output logic                  Busy,
  output logic                  TxDone
);

  localparam int MAX_CYCLES = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_WIDTH  = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_WIDTH-1:0] DEAD_LAST   = CNT_WIDTH'(DEAD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GUARD_RX,
    SETTLE,
    STREAM,
    PA_OFF,
    GUARD_TX
  } state_t;

  state_t                state, stateNext;
  logic [CNT_WIDTH-1:0]  cnt, cntNext;
  logic [LEN_WIDTH-1:0]  remaining, remainingNext;
  logic [DATA_WIDTH-1:0] txReg, txNext;
  logic                  tvReg, tvNext;
  logic                  etReg, etNext;
  logic                  erReg, erNext;
  logic                  readyReg, readyNext;
  logic                  acceptReg, acceptNext;
  logic                  doneReg, doneNext;
  logic                  busyReg, busyNext;
  logic                  transfer;

  // Next-state and next-output logic; PA bias drops on entry to PA_OFF, the DAC register is flushed on its exit.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    remainingNext = remaining;
    txNext        = txReg;
    tvNext        = tvReg;
    etNext        = etReg;
    erNext        = erReg;
    readyNext     = readyReg;
    acceptNext    = 1'b0;
    doneNext      = 1'b0;
    transfer      = (state == STREAM) && readyReg && TxDataValid && !Abort;

    case (state)
      IDLE: begin
        if (TxRequest && (TxLength != '0)) begin
          stateNext     = GUARD_RX;
          remainingNext = TxLength;
          acceptNext    = 1'b1;
          erNext        = 1'b0;
          cntNext       = '0;
        end
      end

      GUARD_RX: begin
        if (Abort) begin
          stateNext = PA_OFF;
          etNext    = 1'b0;
          cntNext   = '0;
        end else if (cnt == DEAD_LAST) begin
          stateNext = SETTLE;
          etNext    = 1'b1;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_WIDTH'(1);
        end
      end

      SETTLE: begin
        if (Abort) begin
          stateNext = PA_OFF;
          etNext    = 1'b0;
          cntNext   = '0;
        end else if (cnt == SETTLE_LAST) begin
          stateNext = STREAM;
          readyNext = 1'b1;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_WIDTH'(1);
        end
      end

      STREAM: begin
        if (Abort) begin
          stateNext = PA_OFF;
          etNext    = 1'b0;
          readyNext = 1'b0;
          txNext    = '0;
          tvNext    = 1'b0;
        end else if (transfer) begin
          txNext        = TxData;
          tvNext        = 1'b1;
          remainingNext = remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) begin
            stateNext = PA_OFF;
            etNext    = 1'b0;
            readyNext = 1'b0;
          end
        end else begin
          txNext = '0;
          tvNext = 1'b0;
        end
      end

      PA_OFF: begin
        stateNext = GUARD_TX;
        txNext    = '0;
        tvNext    = 1'b0;
        etNext    = 1'b0;
        readyNext = 1'b0;
        cntNext   = '0;
      end

      GUARD_TX: begin
        if (cnt == DEAD_LAST) begin
          stateNext = IDLE;
          erNext    = 1'b1;
          doneNext  = 1'b1;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_WIDTH'(1);
        end
      end

      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  // State and output registers; reset forces the antenna straight back to receive.
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state     <= IDLE;
      cnt       <= '0;
      remaining <= '0;
      txReg     <= '0;
      tvReg     <= 1'b0;
      etReg     <= 1'b0;
      erReg     <= 1'b1;
      readyReg  <= 1'b0;
      acceptReg <= 1'b0;
      doneReg   <= 1'b0;
      busyReg   <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      remaining <= remainingNext;
      txReg     <= txNext;
      tvReg     <= tvNext;
      etReg     <= etNext;
      erReg     <= erNext;
      readyReg  <= readyNext;
      acceptReg <= acceptNext;
      doneReg   <= doneNext;
      busyReg   <= busyNext;
    end
  end

  assign TxAccept       = acceptReg;
  assign TxDataReady    = readyReg & ~Abort;
  assign Transmit       = txReg;
  assign TransmitValid  = tvReg;
  assign EnableTransmit = etReg;
  assign EnableReceive  = erReg;
  assign Busy           = busyReg;
  assign TxDone         = doneReg;

endmodule

// File: tb/tb_pa_tx_sequencer.sv
// tb_pa_tx_sequencer: timeline-based reference model, per-cycle compare, directed and random bursts.
module tb_pa_tx_sequencer;

  localparam int D = 4;
  localparam int S = 8;

  logic       Clock = 1'b0;
  logic       ResetN;
  logic       TxRequest;
  logic [7:0] TxLength;
  logic       TxAccept;
  logic [7:0] TxData;
  logic       TxDataValid;
  logic       TxDataReady;
  logic       Abort;
  logic [7:0] Transmit;
  logic       TransmitValid;
  logic       EnableTransmit;
  logic       EnableReceive;
  logic       Busy;
  logic       TxDone;

  pa_tx_sequencer #(
    .DATA_WIDTH(8), .LEN_WIDTH(8), .DEAD_CYCLES(D), .SETTLE_CYCLES(S)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .TxRequest(TxRequest), .TxLength(TxLength),
    .TxAccept(TxAccept), .TxData(TxData), .TxDataValid(TxDataValid),
    .TxDataReady(TxDataReady), .Abort(Abort), .Transmit(Transmit),
    .TransmitValid(TransmitValid), .EnableTransmit(EnableTransmit),
    .EnableReceive(EnableReceive), .Busy(Busy), .TxDone(TxDone)
  );

  // Free-running system clock
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: a burst is described by its accept edge and the edge it ended streaming
  bit   modelValid = 0;
  bit   inRst = 1;
  bit   mActive = 0;
  int   mAccept = 0;
  int   mOff = -1;
  int   mLeft = 0;
  bit   eAccept, eDone, eBusy, eEt, eEr, eReadyFlag, eTv;
  logic [7:0] eTx;

  // Monitor bookkeeping used by the directed scenarios
  int   acceptCount, doneCount, readyRiseCount;
  int   cycAccept, cycDone, cycEtRise, cycEtFall, cycErRise, cycErFall, cycReadyRise;
  bit   busySeen, erLowSeen;
  bit   prevEt = 0, prevEr = 1, prevReady = 0;
  bit   gapOpen = 0;
  int   lowRun = 0;
  logic [7:0] samples[$];
  int   sampleCyc[$];

  // Framer source
  logic [7:0] src [0:15];
  int   srcIdx = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [7:0] len, input logic valid, input logic abt);
    TxRequest   = req;
    TxLength    = len;
    TxDataValid = valid;
    Abort       = abt;
  endtask

  // Advance one clock; the framer steps its source when it saw a handshake in the cycle just ended
  task automatic nextCycle();
    bit hs;
    @(negedge Clock);
    hs = TxDataValid && TxDataReady;
    @(posedge Clock);
    #1;
    if (hs && srcIdx < 15) srcIdx++;
    TxData = src[srcIdx];
  endtask

  task automatic waitDone(input string name, input int limit);
    int start;
    int k;
    start = doneCount;
    k = 0;
    while (doneCount == start && k < limit) begin
      nextCycle();
      k++;
    end
    checkOutput(name, doneCount != start, 1);
  endtask

  task automatic waitIdx(input string name, input int target, input int limit);
    int k;
    k = 0;
    while (srcIdx < target && k < limit) begin
      nextCycle();
      k++;
    end
    checkOutput(name, srcIdx >= target, 1);
  endtask

  task automatic clearMon();
    acceptCount = 0; doneCount = 0; readyRiseCount = 0;
    cycAccept = -1; cycDone = -1; cycEtRise = -1; cycEtFall = -1;
    cycErRise = -1; cycErFall = -1; cycReadyRise = -1;
    busySeen = 0; erLowSeen = 0;
    samples.delete();
    sampleCyc.delete();
  endtask

  // Reference model: outputs follow from the accept edge, the end-of-stream edge and the fixed guard/settle times
  always @(posedge Clock) begin
    cyc++;
    eAccept = 0; eDone = 0; eTv = 0; eTx = 8'h00;
    if (!ResetN) begin
      inRst = 1; mActive = 0; mOff = -1; mLeft = 0;
    end else begin
      inRst = 0;
      if (!mActive) begin
        if (TxRequest && TxLength != 0) begin
          mActive = 1; mAccept = cyc; mLeft = TxLength; mOff = -1; eAccept = 1;
        end
      end else begin
        if (mOff < 0 && Abort) begin
          mOff = cyc;
        end else if (mOff < 0 && cyc > mAccept + D + S && TxDataValid) begin
          eTx = TxData; eTv = 1; mLeft--;
          if (mLeft == 0) mOff = cyc;
        end
        if (mOff >= 0 && cyc == mOff + 1 + D) begin
          mActive = 0; eDone = 1;
        end
      end
    end
    eBusy      = mActive;
    eEr        = !mActive;
    eEt        = mActive && mOff < 0 && cyc >= mAccept + D;
    eReadyFlag = mActive && mOff < 0 && cyc >= mAccept + D + S;
    modelValid = 1;
  end

  // Compare every DUT output against the model each cycle
  always @(negedge Clock) begin
    if (modelValid) begin
      checkOutput("TxAccept", TxAccept, eAccept);
      checkOutput("TxDone", TxDone, eDone);
      checkOutput("Busy", Busy, eBusy);
      checkOutput("EnableTransmit", EnableTransmit, eEt);
      checkOutput("EnableReceive", EnableReceive, eEr);
      checkOutput("TransmitValid", TransmitValid, eTv);
      checkOutput("Transmit", Transmit, eTx);
      checkOutput("TxDataReady", TxDataReady, eReadyFlag && !Abort);
    end
  end

  // Event monitor plus enable exclusivity and guard-gap checker
  always @(negedge Clock) begin
    if (modelValid) begin
      if (!inRst) begin
        checkOutput("enablesExclusive", EnableTransmit & EnableReceive, 0);
        if (!EnableTransmit && !EnableReceive) begin
          lowRun++;
          gapOpen = 1;
        end else begin
          if (gapOpen) checkOutput("enableGap", lowRun >= D, 1);
          gapOpen = 0;
          lowRun = 0;
        end
      end else begin
        gapOpen = 0;
        lowRun = 0;
      end
      if (TxAccept) begin acceptCount++; cycAccept = cyc; end
      if (TxDone) begin doneCount++; cycDone = cyc; end
      if (Busy) busySeen = 1;
      if (!EnableReceive) erLowSeen = 1;
      if (EnableTransmit && !prevEt) cycEtRise = cyc;
      if (!EnableTransmit && prevEt) cycEtFall = cyc;
      if (EnableReceive && !prevEr) cycErRise = cyc;
      if (!EnableReceive && prevEr) cycErFall = cyc;
      if (TxDataReady && !prevReady) begin cycReadyRise = cyc; readyRiseCount++; end
      if (TransmitValid) begin samples.push_back(Transmit); sampleCyc.push_back(cyc); end
      prevEt = EnableTransmit;
      prevEr = EnableReceive;
      prevReady = TxDataReady;
    end
  end

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog at cycle %0d: got running, want finished", cyc);
    $fatal(1, "[TB] simulation timed out");
  end

  // Directed scenarios followed by randomized bursts
  initial begin
    int len;
    int startDone;
    int k;
    for (int i = 0; i < 16; i++) src[i] = 8'h00;
    ResetN = 1'b0;
    TxData = 8'h00;
    applyStimulus(0, 0, 0, 0);
    repeat (3) nextCycle();
    checkOutput("resetEnableReceive", EnableReceive, 1);
    checkOutput("resetEnableTransmit", EnableTransmit, 0);
    checkOutput("resetBusy", Busy, 0);

    // Scenario 1: three-sample burst with continuous data
    $display("[TB] scenario 1: basic burst");
    src[0] = 8'h11; src[1] = 8'h22; src[2] = 8'h33;
    srcIdx = 0; TxData = src[0];
    clearMon();
    ResetN = 1'b1;
    applyStimulus(1, 3, 1, 0);
    nextCycle();
    applyStimulus(0, 3, 1, 0);
    waitDone("s1Done", 60);
    TxDataValid = 0;
    checkOutput("s1AcceptCount", acceptCount, 1);
    checkOutput("s1ErFallWithAccept", cycErFall - cycAccept, 0);
    checkOutput("s1EtRiseDelay", cycEtRise - cycErFall, 4);
    checkOutput("s1ReadyRiseDelay", cycReadyRise - cycEtRise, 8);
    checkOutput("s1SampleCount", samples.size(), 3);
    if (samples.size() == 3) begin
      checkOutput("s1Sample0", samples[0], 8'h11);
      checkOutput("s1Sample1", samples[1], 8'h22);
      checkOutput("s1Sample2", samples[2], 8'h33);
      checkOutput("s1SamplesConsecutive", sampleCyc[2] - sampleCyc[0], 2);
    end
    checkOutput("s1ErRiseAfterEtFall", cycErRise - cycEtFall, 5);
    checkOutput("s1DoneWithErRise", cycDone - cycErRise, 0);
    checkOutput("s1AcceptToDone", cycDone - cycAccept, 20);

    // Scenario 2: zero-length requests are ignored
    $display("[TB] scenario 2: zero length");
    clearMon();
    applyStimulus(1, 0, 0, 0);
    repeat (10) nextCycle();
    applyStimulus(0, 0, 0, 0);
    checkOutput("s2AcceptCount", acceptCount, 0);
    checkOutput("s2BusySeen", busySeen, 0);
    checkOutput("s2ErLowSeen", erLowSeen, 0);

    // Scenario 3: underrun of three cycles between beats 2 and 3
    $display("[TB] scenario 3: underrun");
    for (int i = 0; i < 4; i++) src[i] = 8'hA1 + 8'(i);
    srcIdx = 0; TxData = src[0];
    clearMon();
    applyStimulus(1, 4, 1, 0);
    nextCycle();
    applyStimulus(0, 4, 1, 0);
    waitIdx("s3TwoBeats", 2, 40);
    TxDataValid = 0;
    repeat (3) nextCycle();
    TxDataValid = 1;
    waitDone("s3Done", 60);
    TxDataValid = 0;
    checkOutput("s3SampleCount", samples.size(), 4);
    if (samples.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput("s3Sample", samples[i], 8'hA1 + 8'(i));
      checkOutput("s3UnderrunGap", sampleCyc[2] - sampleCyc[1], 4);
    end
    checkOutput("s3AcceptToDone", cycDone - cycAccept, 24);

    // Scenario 4: abort after two of five samples
    $display("[TB] scenario 4: abort");
    for (int i = 0; i < 5; i++) src[i] = 8'h51 + 8'(i);
    srcIdx = 0; TxData = src[0];
    clearMon();
    applyStimulus(1, 5, 1, 0);
    nextCycle();
    applyStimulus(0, 5, 1, 0);
    waitIdx("s4TwoBeats", 2, 40);
    Abort = 1;
    nextCycle();
    Abort = 0;
    waitDone("s4Done", 60);
    TxDataValid = 0;
    checkOutput("s4SampleCount", samples.size(), 2);
    checkOutput("s4ReadyRises", readyRiseCount, 1);
    if (samples.size() == 2) checkOutput("s4EtFallNextCycle", cycEtFall - sampleCyc[1], 1);
    checkOutput("s4ErRiseAfterEtFall", cycErRise - cycEtFall, 5);
    checkOutput("s4DoneWithErRise", cycDone - cycErRise, 0);

    // Scenario 5: reset in the middle of streaming
    $display("[TB] scenario 5: reset mid-stream");
    for (int i = 0; i < 8; i++) src[i] = 8'h61 + 8'(i);
    srcIdx = 0; TxData = src[0];
    clearMon();
    applyStimulus(1, 8, 1, 0);
    nextCycle();
    applyStimulus(0, 8, 1, 0);
    waitIdx("s5ThreeBeats", 3, 40);
    ResetN = 0;
    nextCycle();
    checkOutput("s5EnableTransmit", EnableTransmit, 0);
    checkOutput("s5EnableReceive", EnableReceive, 1);
    checkOutput("s5TransmitValid", TransmitValid, 0);
    checkOutput("s5Busy", Busy, 0);
    ResetN = 1;
    applyStimulus(0, 0, 0, 0);
    repeat (2) nextCycle();

    // Randomized bursts with underruns, aborts and requests while busy
    $display("[TB] random bursts");
    for (int b = 0; b < 40; b++) begin
      for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
      srcIdx = 0; TxData = src[0];
      len = $urandom_range(0, 6);
      startDone = doneCount;
      applyStimulus(1, 8'(len), ($urandom % 4) != 0, 0);
      nextCycle();
      k = 0;
      while (len != 0 && doneCount == startDone && k < 120) begin
        applyStimulus(Busy && (($urandom % 6) == 0), 8'($urandom_range(0, 9)),
                      ($urandom % 4) != 0, ($urandom % 30) == 0);
        nextCycle();
        k++;
      end
      if (len != 0) checkOutput("randomDone", doneCount != startDone, 1);
      applyStimulus(0, 0, 0, 0);
      k = 0;
      while (Busy && k < 100) begin
        nextCycle();
        k++;
      end
      nextCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
